// File: rtl/gin_tag_injector_if.sv
// Source-stream and GIN-input handshake bundle for the tag injector.
interface gin_tag_injector_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ROW_TAG_WIDTH = 4,
    parameter int unsigned COL_TAG_WIDTH = 4
);
    // Untagged source word stream
    logic                     src_valid;
    logic [DATA_WIDTH-1:0]    src_data;
    logic                     src_ready;

    // Tagged word toward the GIN input
    logic [DATA_WIDTH-1:0]    data_out;
    logic [ROW_TAG_WIDTH-1:0] row_tag_out;
    logic [COL_TAG_WIDTH-1:0] col_tag_out;
    logic                     enable_out;
    logic                     ready_in;

    // Injector side
    modport master (
        input  src_valid, src_data, ready_in,
        output src_ready, data_out, row_tag_out, col_tag_out, enable_out
    );

    // Environment side (source and GIN)
    modport slave (
        output src_valid, src_data, ready_in,
        input  src_ready, data_out, row_tag_out, col_tag_out, enable_out
    );
endinterface

// File: rtl/gin_tag_injector.sv
// Stamps source words with row/col tags from a rectangular schedule and
// buffers them in a small FIFO toward the GIN input.
module gin_tag_injector #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ROW_TAG_WIDTH = 4,
    parameter int unsigned COL_TAG_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     link_clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_row_base,
    input  logic [COL_TAG_WIDTH-1:0] cfg_col_base,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_num_rows,
    input  logic [COL_TAG_WIDTH-1:0] cfg_num_cols,
    gin_tag_injector_if.master       bus,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [ROW_TAG_WIDTH-1:0] row;
        logic [COL_TAG_WIDTH-1:0] col;
    } entry_t;

    state_e                   state_q, state_d;
    logic [ROW_TAG_WIDTH-1:0] row_base_q, row_base_d;
    logic [COL_TAG_WIDTH-1:0] col_base_q, col_base_d;
    logic [ROW_TAG_WIDTH-1:0] num_rows_q, num_rows_d;
    logic [COL_TAG_WIDTH-1:0] num_cols_q, num_cols_d;
    logic [ROW_TAG_WIDTH-1:0] r_cnt_q, r_cnt_d;
    logic [COL_TAG_WIDTH-1:0] c_cnt_q, c_cnt_d;
    logic                     done_q, done_d;

    entry_t                   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     last_col;
    logic                     last_row;
    entry_t                   push_entry;
    entry_t                   head_entry;

    // FIFO status and handshake qualification from registered state only
    assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty    = (count_q == '0);
    assign bus.src_ready = (state_q == ST_RUN) && !fifo_full;
    assign push          = bus.src_valid && bus.src_ready;
    assign pop           = bus.enable_out && bus.ready_in;

    // Schedule position and the tag attached to the word being accepted
    assign last_col        = (c_cnt_q == (num_cols_q - COL_TAG_WIDTH'(1)));
    assign last_row        = (r_cnt_q == (num_rows_q - ROW_TAG_WIDTH'(1)));
    assign push_entry.data = bus.src_data;
    assign push_entry.row  = row_base_q + r_cnt_q;
    assign push_entry.col  = col_base_q + c_cnt_q;

    // Head entry drives the GIN input directly
    assign head_entry      = mem_q[rd_ptr_q];
    assign bus.enable_out  = !fifo_empty;
    assign bus.data_out    = head_entry.data;
    assign bus.row_tag_out = head_entry.row;
    assign bus.col_tag_out = head_entry.col;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    // Next-state, config latch and schedule counter logic
    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        col_base_d = col_base_q;
        num_rows_d = num_rows_q;
        num_cols_d = num_cols_q;
        r_cnt_d    = r_cnt_q;
        c_cnt_d    = c_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    row_base_d = cfg_row_base;
                    col_base_d = cfg_col_base;
                    num_rows_d = cfg_num_rows;
                    num_cols_d = cfg_num_cols;
                    r_cnt_d    = '0;
                    c_cnt_d    = '0;
                    if ((cfg_num_rows == '0) || (cfg_num_cols == '0)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (push) begin
                    if (last_col) begin
                        c_cnt_d = '0;
                        r_cnt_d = r_cnt_q + ROW_TAG_WIDTH'(1);
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        c_cnt_d = c_cnt_q + COL_TAG_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and schedule registers
    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_base_q <= '0;
            col_base_q <= '0;
            num_rows_q <= '0;
            num_cols_q <= '0;
            r_cnt_q    <= '0;
            c_cnt_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_base_q <= col_base_d;
            num_rows_q <= num_rows_d;
            num_cols_q <= num_cols_d;
            r_cnt_q    <= r_cnt_d;
            c_cnt_q    <= c_cnt_d;
            done_q     <= done_d;
        end
    end

    // Tagged-word FIFO storage, pointers and occupancy
    always_ff @(posedge link_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_gin_tag_injector.sv
// Randomized bench for gin_tag_injector against a schedule-level reference model.
module tb_gin_tag_injector;

    localparam int unsigned DW    = 64;
    localparam int unsigned RW    = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          link_clk = 1'b0;
    logic          reset    = 1'b1;
    logic          cfg_start;
    logic [RW-1:0] cfg_row_base;
    logic [CW-1:0] cfg_col_base;
    logic [RW-1:0] cfg_num_rows;
    logic [CW-1:0] cfg_num_cols;
    logic          busy;
    logic          done;

    gin_tag_injector_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW)) bus ();

    gin_tag_injector #(
        .DATA_WIDTH   (DW),
        .ROW_TAG_WIDTH(RW),
        .COL_TAG_WIDTH(CW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .link_clk    (link_clk),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .cfg_row_base(cfg_row_base),
        .cfg_col_base(cfg_col_base),
        .cfg_num_rows(cfg_num_rows),
        .cfg_num_cols(cfg_num_cols),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done)
    );

    always #5 link_clk = ~link_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".enable"},    64'(bus.enable_out),  64'd0);
        check({tag, ".src_ready"}, 64'(bus.src_ready),   64'd0);
        check({tag, ".busy"},      64'(busy),            64'd0);
        check({tag, ".done"},      64'(done),            64'd0);
        check({tag, ".data"},      64'(bus.data_out),    64'd0);
        check({tag, ".row"},       64'(bus.row_tag_out), 64'd0);
        check({tag, ".col"},       64'(bus.col_tag_out), 64'd0);
    endtask

    // One transfer: schedule (rb,cb,nr,nc); valid/ready percentages; ready held
    // low for the first 'stall' cycles; optional reset after 'abort_at' accepts.
    task automatic run_xfer(input int rb, input int cb, input int nr, input int nc,
                            input int vpct, input int rpct, input int stall,
                            input int abort_at, input bit rnd_data, input string name);
        int            total;
        int            acc;
        int            popd;
        int            occ;
        int            empty_seen;
        int            cyc;
        bit            fin;
        bit            push;
        bit            pop;
        logic [DW-1:0] nxt;

        total      = nr * nc;
        acc        = 0;
        popd       = 0;
        empty_seen = 0;
        cyc        = 0;
        fin        = 1'b0;
        q.delete();
        nxt = rnd_data ? {32'($urandom), 32'($urandom)} : 64'd0;

        @(posedge link_clk); #1;
        cfg_start     = 1'b1;
        cfg_row_base  = RW'(rb);
        cfg_col_base  = CW'(cb);
        cfg_num_rows  = RW'(nr);
        cfg_num_cols  = CW'(nc);
        bus.src_valid = 1'b0;
        bus.ready_in  = 1'b0;
        @(posedge link_clk); #1;
        cfg_start    = 1'b0;
        cfg_row_base = RW'($urandom);
        cfg_col_base = CW'($urandom);
        cfg_num_rows = RW'($urandom);
        cfg_num_cols = CW'($urandom);

        while (!fin) begin
            bus.src_valid = ($urandom_range(99) < vpct);
            bus.src_data  = nxt;
            bus.ready_in  = (cyc >= stall) && ($urandom_range(99) < rpct);
            cfg_start     = (acc < total) && ($urandom_range(7) == 0);

            @(negedge link_clk);
            occ = acc - popd;
            if ((acc == total) && (occ == 0)) empty_seen++;
            check({name, ".enable"},    64'(bus.enable_out), 64'(occ > 0));
            check({name, ".src_ready"}, 64'(bus.src_ready),  64'((acc < total) && (occ < DEPTH)));
            check({name, ".busy"},      64'(busy),           64'(empty_seen != 2));
            check({name, ".done"},      64'(done),           64'(empty_seen == 2));
            if (occ > 0) begin
                check({name, ".data"}, 64'(bus.data_out),    64'(q[0].data));
                check({name, ".row"},  64'(bus.row_tag_out), 64'(q[0].row));
                check({name, ".col"},  64'(bus.col_tag_out), 64'(q[0].col));
            end
            fin = (empty_seen == 2);

            push = bus.src_valid && (acc < total) && (occ < DEPTH);
            pop  = (occ > 0) && bus.ready_in;
            if (pop) begin
                void'(q.pop_front());
                popd++;
            end
            if (push) begin
                q.push_back(exp_t'{nxt, RW'(rb + acc / nc), CW'(cb + acc % nc)});
                acc++;
                nxt = rnd_data ? {32'($urandom), 32'($urandom)} : nxt + 64'd1;
            end

            cyc++;
            if (cyc > 5000) begin
                check({name, ".timeout"}, 64'd1, 64'd0);
                fin = 1'b1;
            end

            @(posedge link_clk); #1;
            if (!fin && (abort_at > 0) && (acc == abort_at)) begin
                check({name, ".buffered_before_abort"}, 64'(bus.enable_out), 64'((acc - popd) > 0));
                reset = 1'b1;
                #1;
                check_reset_outputs({name, ".abort"});
                @(posedge link_clk); #1;
                reset = 1'b0;
                fin   = 1'b1;
            end
        end

        cfg_start     = 1'b0;
        bus.src_valid = 1'b0;
        bus.ready_in  = 1'b0;
    endtask

    initial begin
        cfg_start     = 1'b0;
        cfg_row_base  = '0;
        cfg_col_base  = '0;
        cfg_num_rows  = '0;
        cfg_num_cols  = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.ready_in  = 1'b0;
        reset         = 1'b1;

        repeat (2) @(posedge link_clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        run_xfer(2, 5, 2, 3, 100, 100, 0, 0, 1'b0, "basic");
        run_xfer(2, 5, 2, 3, 100, 100, 8, 0, 1'b0, "backpressure");
        run_xfer(15, 14, 2, 3, 80, 80, 0, 0, 1'b1, "wrap");
        run_xfer(2, 5, 3, 0, 100, 100, 0, 0, 1'b1, "zero_cols");
        run_xfer(2, 5, 0, 3, 100, 100, 0, 0, 1'b1, "zero_rows");
        run_xfer(1, 1, 3, 3, 100, 100, 2, 3, 1'b1, "abort");
        run_xfer(7, 9, 2, 2, 70, 70, 0, 0, 1'b1, "after_abort");
        run_xfer(int'($urandom_range(15)), int'($urandom_range(15)), 12, 14, 60, 60, 0, 0, 1'b1, "random_12x14");
        for (int i = 0; i < 4; i++) begin
            run_xfer(int'($urandom_range(15)), int'($urandom_range(15)),
                     int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                     int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                     0, 0, 1'b1, "random_small");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/gin_tag_injector.md
Name: gin_tag_injector

Overview:
Upstream feeder for the global input network (GIN). It takes an untagged word stream from the global buffer read port and stamps each word with a row/col destination tag from a configured rectangular PE-range schedule. Tagged words are held in a small FIFO and presented to the GIN input through its enable/ready handshake. It absorbs GIN back-pressure, which occurs whenever any row MCC or X-bus is not ready, without losing or reordering words.

Parameters:
DATA_WIDTH, 64, payload width; equals the GIN DATA_WIDTH
ROW_TAG_WIDTH, 4, row tag width; equals the GIN ROW_TAG_WIDTH
COL_TAG_WIDTH, 4, col tag width; equals the GIN COL_TAG_WIDTH
FIFO_DEPTH, 4, tagged-word FIFO entries; power of 2, >=2

Ports:
link_clk  in  1  clock; one clock domain, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle pulse that starts a transfer; honoured only in IDLE
cfg_row_base  in  ROW_TAG_WIDTH  first row tag
cfg_col_base  in  COL_TAG_WIDTH  first col tag
cfg_num_rows  in  ROW_TAG_WIDTH  rows in the schedule; 0 means empty transfer
cfg_num_cols  in  COL_TAG_WIDTH  cols per row; 0 means empty transfer
src_valid  in  1  source word valid
src_data  in  DATA_WIDTH  source word
src_ready  out  1  injector accepts the word this cycle
data_out  out  DATA_WIDTH  to GIN data_in
row_tag_out  out  ROW_TAG_WIDTH  to GIN row_tag
col_tag_out  out  COL_TAG_WIDTH  to GIN col_tag
enable_out  out  1  to GIN enable_in; FIFO head valid
ready_in  in  1  from GIN ready_out
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a transfer has fully drained

Behaviour:
- Transfer rules:
  - Source transfer: src_valid && src_ready on a link_clk edge.
  - GIN transfer: enable_out && ready_in on a link_clk edge.
- Reset (async, immediate):
  - State = IDLE; FIFO empty; r_cnt = c_cnt = 0.
  - Outputs: src_ready = 0, enable_out = 0, busy = 0, done = 0, data_out = 0, row_tag_out = 0, col_tag_out = 0.
  - Reset mid-transfer discards all buffered words; no partial output afterwards.
- FSM IDLE:
  - On cfg_start, latch all cfg_* fields and clear counters.
  - If num_rows == 0 or num_cols == 0, go to DRAIN. Otherwise go to RUN.
- FSM RUN:
  - src_ready = !fifo_full. It is a combinational function of registered state only, with no dependence on ready_in.
  - Each accepted word is pushed with row tag = (row_base + r_cnt) mod 2^ROW_TAG_WIDTH and col tag = (col_base + c_cnt) mod 2^COL_TAG_WIDTH.
  - Counter update: if c_cnt == num_cols-1, then c_cnt = 0 and r_cnt++. Otherwise c_cnt++.
  - Pushing the word with r_cnt == num_rows-1 and c_cnt == num_cols-1 moves the FSM to DRAIN.
- FSM DRAIN:
  - src_ready = 0.
  - When the FIFO is empty, pulse done for exactly one cycle and move to IDLE on the same edge.
- cfg_start in RUN or DRAIN is ignored; cfg_* changes after latching have no effect.
- FIFO:
  - enable_out = !fifo_empty. data_out and the tag outputs come from the head entry and are stable while enable_out && !ready_in.
  - A word accepted at edge N appears on the outputs after edge N (visible in cycle N+1). There is no same-cycle bypass.
  - Push and pop on the same edge: both occur and occupancy is unchanged.
  - Full: src_ready = 0, even if a pop happens that cycle.
  - Empty: enable_out = 0; ready_in is ignored.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
- Throughput: 1 word/cycle sustained when ready_in stays high.
- Output ordering equals source ordering; no word is duplicated or dropped.

Test Plan:
1. Reset, then cfg_start with row_base=2, col_base=5, num_rows=2, num_cols=3; src_valid held 1 with data 0..5; ready_in=1 -> 6 GIN transfers with tags (2,5)(2,6)(2,7)(3,5)(3,6)(3,7) and data 0..5 in order. First enable_out appears the cycle after the first accept. done pulses once, then busy=0.
2. Same config with ready_in=0 -> after 4 accepts src_ready=0 and enable_out=1 with data 0 and tag (2,5) held stable. Release ready_in -> all 6 words delivered in order.
3. row_base=15, col_base=14, num_rows=2, num_cols=3 -> tags (15,14)(15,15)(15,0)(0,14)(0,15)(0,0).
4. num_cols=0 with cfg_start -> no src_ready and no enable_out; busy=1 for 1 cycle, done pulses, return to IDLE.
5. Assert reset after 3 accepts while 2 words are still buffered -> enable_out and busy drop at once. Post-reset start with new config -> only new-transfer data and tags observed.
6. Random src_valid/ready_in toggling over 12x14 transfer (num_rows=12, num_cols=14) -> 168 words, scoreboard order/tag match, no overflow, done exactly once.
